// File: rtl/cmd_response_tx.sv
// cmd_response_tx
// Response transmitter that sits after the command front-end. It captures the
// command serial number (CSN) and command code (CC) from the receive stream,
// buffers the handler's payload words, and on cmd_done / cmd_illegal emits one
// AXI-Stream frame: RSN, RC, RDC, RD1..RDn.
//
// Optional build macro: CMD_RESP_CHECKSUM_EN appends an XOR checksum word
// covering every earlier word of the frame; tx_tlast then moves to that word.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   rx_tdata                receive-stream data beat
//   ser_num_le, command_le  latch rx_tdata as CSN / CC
//   pl_wr, pl_data          payload word write from the command handler
//   cmd_done, cmd_illegal   one-cycle frame triggers (illegal has priority)
//   tx_tdata/tvalid/tready/tlast/tkeep  32-bit AXI-Stream transmit side
//   csn, cc                 latched serial number / command code
//   resp_busy               frame being built or sent
//   pl_overflow             sticky payload-drop flag, cleared at end of frame
module cmd_response_tx #(
  parameter int PAYLOAD_DEPTH = 16,
  parameter int ILLEGAL_BIT   = 31,
  parameter int OVERFLOW_BIT  = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rx_tdata,
  input  logic        ser_num_le,
  input  logic        command_le,
  input  logic        pl_wr,
  input  logic [31:0] pl_data,
  input  logic        cmd_done,
  input  logic        cmd_illegal,
  output logic [31:0] tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        tx_tlast,
  output logic [3:0]  tx_tkeep,
  output logic [31:0] csn,
  output logic [31:0] cc,
  output logic        resp_busy,
  output logic        pl_overflow
);

  localparam int AW = $clog2(PAYLOAD_DEPTH);
  localparam int CW = $clog2(PAYLOAD_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(PAYLOAD_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, SEND_RSN, SEND_RC, SEND_RDC, SEND_DATA, SEND_CSUM, DONE
  } state_t;

`ifdef CMD_RESP_CHECKSUM_EN
  localparam state_t AFTER_DATA = SEND_CSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t        state, state_nxt;
  logic [31:0]   mem [PAYLOAD_DEPTH];
  logic [CW-1:0] pl_cnt, rdc, rd_idx;
  logic [31:0]   hdr_rsn, hdr_rc, csum;
  logic          illegal_q;
  logic          hs, trigger, last_data, pl_store;

  assign hs        = tx_tvalid & tx_tready;
  assign trigger   = (state == IDLE) & (cmd_done | cmd_illegal);
  assign last_data = (rd_idx == (rdc - CW'(1)));
  assign pl_store  = pl_wr & (state == IDLE) & (pl_cnt < DEPTH_C);
  assign tx_tkeep  = 4'b1111;
  assign resp_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (trigger) state_nxt = START;
      START:     state_nxt = SEND_RSN;
      SEND_RSN:  if (hs) state_nxt = SEND_RC;
      SEND_RC:   if (hs) state_nxt = SEND_RDC;
      SEND_RDC:  if (hs) state_nxt = (rdc != '0) ? SEND_DATA : AFTER_DATA;
      SEND_DATA: if (hs && last_data) state_nxt = AFTER_DATA;
      SEND_CSUM: if (hs) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output words are driven from the frame snapshot, so they hold steady
  // under backpressure and drop to zero as soon as reset forces IDLE.
  always_comb begin
    tx_tvalid = 1'b0;
    tx_tdata  = '0;
    tx_tlast  = 1'b0;
    case (state)
      SEND_RSN: begin
        tx_tvalid = 1'b1;
        tx_tdata  = hdr_rsn;
      end
      SEND_RC: begin
        tx_tvalid = 1'b1;
        tx_tdata  = hdr_rc;
      end
      SEND_RDC: begin
        tx_tvalid = 1'b1;
        tx_tdata  = {{(32-CW){1'b0}}, rdc};
        tx_tlast  = (rdc == '0) && (AFTER_DATA == DONE);
      end
      SEND_DATA: begin
        tx_tvalid = 1'b1;
        tx_tdata  = mem[rd_idx[AW-1:0]];
        tx_tlast  = last_data && (AFTER_DATA == DONE);
      end
      SEND_CSUM: begin
        tx_tvalid = 1'b1;
        tx_tdata  = csum;
        tx_tlast  = 1'b1;
      end
      default: ;
    endcase
  end

  // Control state: latches, payload count, overflow flag, read index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csn         <= '0;
      cc          <= '0;
      pl_cnt      <= '0;
      pl_overflow <= 1'b0;
      illegal_q   <= 1'b0;
      rdc         <= '0;
      rd_idx      <= '0;
    end else begin
      if (ser_num_le) csn <= rx_tdata;
      if (command_le) cc  <= rx_tdata;
      if (trigger) illegal_q <= cmd_illegal;
      if (state == START) begin
        rdc    <= illegal_q ? '0 : pl_cnt;
        rd_idx <= '0;
      end
      if ((state == SEND_DATA) && hs) rd_idx <= rd_idx + CW'(1);
      if (state == DONE) begin
        pl_cnt      <= '0;
        pl_overflow <= 1'b0;
      end
      // A word dropped in DONE still marks overflow for the next frame.
      if (pl_store)   pl_cnt      <= pl_cnt + CW'(1);
      else if (pl_wr) pl_overflow <= 1'b1;
    end
  end

  // Frame data: payload buffer, header snapshot, running checksum.
  always_ff @(posedge clk) begin
    if (pl_store) mem[pl_cnt[AW-1:0]] <= pl_data;
    if (state == START) begin
      hdr_rsn <= csn;
      hdr_rc  <= cc;
      if (illegal_q)   hdr_rc[ILLEGAL_BIT]  <= 1'b1;
      if (pl_overflow) hdr_rc[OVERFLOW_BIT] <= 1'b1;
      csum    <= '0;
    end else if (hs) begin
      csum <= csum ^ tx_tdata;
    end
  end

endmodule
